// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt vector controller.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Width of the request-hold / gap counter (both limited to 1..255).
  localparam int CNT_W = 8;

  // Width of a binary port index; never narrower than one bit.
  function automatic int idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: one-hot and binary index of the winning request.
module priority_encoder
  import intr_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  localparam int IW               = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IW-1:0]    o_idx
);

  // Scan so that the highest-priority request is the last one written.
  always_comb begin
    o_valid  = |i_req;
    o_onehot = '0;
    o_idx    = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IW'(i);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_req[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/intr_vec_ctrl.sv
// Interrupt vector controller: edge/level capture into sticky pending bits,
// fixed-priority arbitration and a serialised request/ack/gap vector stream.
module intr_vec_ctrl
  import intr_pkg::*;
#(
  parameter int             PORTS       = 4,
  parameter logic [PORTS-1:0] EDGE_MODE = {PORTS{1'b1}},
  parameter int             INTR_CYCLES = 1,
  parameter int             GAP_CYCLES  = 1,
  parameter bit             USE_ACK     = 1'b1,
  localparam int            IW          = idx_w(PORTS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PORTS-1:0] i_intr,
  input  logic [PORTS-1:0] i_intr_en,
  input  logic             i_intr_vec_ack,
  output logic             o_intr_vec_req,
  output logic [31:0]      o_intr_num,
  output logic [IW-1:0]    o_intr_idx,
  output logic [PORTS-1:0] o_intr_pending,
  output logic [PORTS-1:0] o_intr_lost
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PORTS-1:0] r_intr_q;
  logic [PORTS-1:0] r_pending;
  logic [PORTS-1:0] r_lost;
  logic [PORTS-1:0] r_sel;
  logic [IW-1:0]    r_idx;
  logic             r_ack_seen;

  state_e           w_next_state;
  logic [PORTS-1:0] w_edge_evt;
  logic [PORTS-1:0] w_evt;
  logic [PORTS-1:0] w_clr;
  logic [PORTS-1:0] w_pe_onehot;
  logic [IW-1:0]    w_pe_idx;
  logic             w_pe_vld;

  assign w_edge_evt = i_intr & ~r_intr_q & EDGE_MODE;
  assign w_evt      = w_edge_evt | (i_intr & ~EDGE_MODE);
  // The serviced port is released in the single DONE cycle.
  assign w_clr      = (r_state == DONE) ? r_sel : '0;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1)
  ) u_prio (
    .i_req    (r_pending & i_intr_en),
    .o_valid  (w_pe_vld),
    .o_onehot (w_pe_onehot),
    .o_idx    (w_pe_idx)
  );

  // Capture events into sticky pending bits; a new event beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_intr_q  <= '0;
      r_pending <= '0;
      r_lost    <= '0;
    end else begin
      r_intr_q  <= i_intr;
      r_pending <= (r_pending & ~w_clr) | w_evt;
      r_lost    <= w_edge_evt & r_pending & ~w_clr;
    end
  end

  // State register plus the counter, latched winner and sticky ack flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_idx      <= '0;
      r_ack_seen <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (w_pe_vld) begin
          r_cnt      <= CNT_W'(INTR_CYCLES);
          r_sel      <= w_pe_onehot;
          r_idx      <= w_pe_idx;
          r_ack_seen <= 1'b0;
        end
        REQ: begin
          if (r_cnt > CNT_ONE) r_cnt <= r_cnt - CNT_ONE;
          if (i_intr_vec_ack) r_ack_seen <= 1'b1;
        end
        DONE: r_cnt <= CNT_W'(GAP_CYCLES);
        GAP:  if (r_cnt > CNT_ONE) r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Next-state: hold REQ until the minimum time is served and, if required, acked.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_pe_vld) w_next_state = REQ;
      REQ:  if (r_cnt == CNT_ONE && (!USE_ACK || r_ack_seen || i_intr_vec_ack))
              w_next_state = DONE;
      DONE: w_next_state = GAP;
      GAP:  if (r_cnt == CNT_ONE) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: the vector is only visible while requesting.
  always_comb begin
    o_intr_vec_req = (r_state == REQ);
    o_intr_num     = '0;
    o_intr_idx     = '0;
    if (r_state == REQ) begin
      o_intr_num = 32'(r_sel);
      o_intr_idx = r_idx;
    end
    o_intr_pending = r_pending;
    o_intr_lost    = r_lost;
  end

endmodule

// File: tb/tb_intr_vec_ctrl.sv
// Bench for intr_vec_ctrl: two configurations (no-ack with a level port,
// ack-handshake all-edge) share stimulus; a behavioural model predicts the
// vector stream and a negedge monitor pops and compares it.
module tb_intr_vec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] intr = '0;
  logic [3:0] en = '0;
  logic       ack = 1'b0;

  logic       a_req, b_req;
  logic [31:0] a_num, b_num;
  logic [1:0] a_idx, b_idx;
  logic [3:0] a_pend, b_pend, a_lost, b_lost;

  always #5 clk = ~clk;

  intr_vec_ctrl #(.PORTS(4), .EDGE_MODE(4'b1110), .INTR_CYCLES(2),
                  .GAP_CYCLES(1), .USE_ACK(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_intr(intr), .i_intr_en(en),
    .i_intr_vec_ack(ack), .o_intr_vec_req(a_req), .o_intr_num(a_num),
    .o_intr_idx(a_idx), .o_intr_pending(a_pend), .o_intr_lost(a_lost));

  intr_vec_ctrl #(.PORTS(4), .EDGE_MODE(4'b1111), .INTR_CYCLES(2),
                  .GAP_CYCLES(2), .USE_ACK(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_intr(intr), .i_intr_en(en),
    .i_intr_vec_ack(ack), .o_intr_vec_req(b_req), .o_intr_num(b_num),
    .o_intr_idx(b_idx), .o_intr_pending(b_pend), .o_intr_lost(b_lost));

  int n_chk = 0;
  int n_fail = 0;

  // Model configuration per instance (0 = u_a, 1 = u_b).
  logic [3:0] m_edge[2]   = '{4'b1110, 4'b1111};
  int         m_intrc[2]  = '{2, 2};
  int         m_gap[2]    = '{1, 2};
  bit         m_useack[2] = '{1'b0, 1'b1};

  // Model state: pending set, last line values, port in service (-1 none),
  // cycles it has been requested, ack seen, cycles of enforced quiet left,
  // and the port to release at the coming edge.
  logic [3:0] m_pend[2], m_q[2], m_lost[2];
  int         m_srv[2], m_held[2], m_cool[2], m_clr[2];
  bit         m_ackd[2];
  int         q_a[$], q_b[$];

  bit         prev_req[2];
  int         cur_exp[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    logic [3:0] eedge, evt, clrm, cand;
    int w;
    if (!rst_n) begin
      m_pend[m] = '0; m_q[m] = '0; m_lost[m] = '0;
      m_srv[m] = -1; m_held[m] = 0; m_cool[m] = 0; m_clr[m] = -1; m_ackd[m] = 1'b0;
      if (m == 0) q_a.delete(); else q_b.delete();
      return;
    end
    eedge = intr & ~m_q[m] & m_edge[m];
    evt   = eedge | (intr & ~m_edge[m]);
    clrm  = (m_clr[m] >= 0) ? 4'(1 << m_clr[m]) : 4'b0000;
    m_lost[m] = eedge & m_pend[m] & ~clrm;
    cand  = m_pend[m] & en;
    m_clr[m] = -1;
    if (m_srv[m] >= 0) begin
      m_ackd[m] = m_ackd[m] | ack;
      if (m_held[m] >= m_intrc[m] && (!m_useack[m] || m_ackd[m])) begin
        m_clr[m]  = m_srv[m];
        m_srv[m]  = -1;
        m_cool[m] = 1 + m_gap[m];
      end else begin
        m_held[m]++;
      end
    end else if (m_cool[m] > 0) begin
      m_cool[m]--;
    end else if (cand != 0) begin
      w = 0;
      while (!cand[w]) w++;
      m_srv[m] = w; m_held[m] = 1; m_ackd[m] = 1'b0;
      if (m == 0) q_a.push_back(w); else q_b.push_back(w);
    end
    m_pend[m] = (m_pend[m] & ~clrm) | evt;
    m_q[m] = intr;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic check_inst(input int m, input logic req, input logic [31:0] num,
                            input logic [1:0] idx, input logic [3:0] pend, input logic [3:0] lost);
    string s;
    s = (m == 0) ? "A" : "B";
    chk({s, ".req"}, 32'(req), 32'(m_srv[m] >= 0));
    chk({s, ".pending"}, 32'(pend), 32'(m_pend[m]));
    chk({s, ".lost"}, 32'(lost), 32'(m_lost[m]));
    if (req && !prev_req[m]) begin
      if ((m == 0 && q_a.size() == 0) || (m == 1 && q_b.size() == 0)) begin
        n_chk++; n_fail++;
        $display("FAIL %s.vector_unexpected act=req exp=none t=%0t", s, $time);
        cur_exp[m] = -1;
      end else begin
        cur_exp[m] = (m == 0) ? q_a.pop_front() : q_b.pop_front();
      end
    end
    if (req) begin
      chk({s, ".num"}, num, (cur_exp[m] >= 0) ? 32'(1 << cur_exp[m]) : 32'hFFFF_FFFF);
      chk({s, ".idx"}, 32'(idx), 32'(cur_exp[m]));
    end else begin
      chk({s, ".num_idle"}, num, 32'h0);
      chk({s, ".idx_idle"}, 32'(idx), 32'h0);
    end
    prev_req[m] = req;
  endtask

  always @(negedge clk) begin
    check_inst(0, a_req, a_num, a_idx, a_pend, a_lost);
    check_inst(1, b_req, b_num, b_idx, b_pend, b_lost);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    prev_req = '{1'b0, 1'b0};
    cur_exp  = '{-1, -1};
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1; en = 4'hF; ack = 1'b1;
    // Two ports in one pulse: serviced in index order.
    intr = 4'b0110; step(1); intr = 4'b0000; step(20);
    // Withheld ack: the ack configuration holds its request.
    ack = 1'b0;
    intr = 4'b1000; step(1); intr = 4'b0000; step(12);
    ack = 1'b1; step(1); ack = 1'b0; step(10);
    ack = 1'b1;
    // Higher-priority arrival during the gap wins over an older pending port.
    intr = 4'b0100; step(1); intr = 4'b0000; step(1);
    intr = 4'b0010; step(1); intr = 4'b0000; step(2);
    intr = 4'b0001; step(1); intr = 4'b0000; step(25);
    // Second edge on a pending (masked) port raises a lost pulse.
    en = 4'b1011;
    intr = 4'b0100; step(1); intr = 4'b0000; step(1);
    intr = 4'b0100; step(1); intr = 4'b0000; step(2);
    en = 4'hF; step(15);
    // Long high on port 0: level port re-pends, edge port fires once.
    intr = 4'b0001; step(20); intr = 4'b0000; step(15);
    // Masked pending, release, then reset during the request.
    en = 4'b0000; ack = 1'b0;
    intr = 4'b0010; step(1); intr = 4'b0000; step(5);
    en = 4'hF;
    for (int i = 0; i < 20 && !b_req; i++) step(1);
    chk("s6.req_seen", 32'(b_req), 32'h1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; ack = 1'b1; step(5);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      intr  = 4'($urandom & $urandom & $urandom);
      en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      ack   = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    // Drain everything that is still pending.
    rst_n = 1'b1; intr = 4'b0000; en = 4'hF; ack = 1'b1;
    step(60);
    chk("drain.queue_a", 32'(q_a.size()), 32'h0);
    chk("drain.queue_b", 32'(q_b.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
